// File: rtl/operand_unpacker_pkg.sv
// rtl/operand_unpacker_pkg.sv - operand classes and IEEE-754 single-precision constants
// Package operand:
//   operand_class  ZERO/SUBNORMAL/NORMAL/INF/QNAN/SNAN
//   BIAS, EXP_MAX, ZERO_EXP, INF_EXP
//   classify()     maps raw exponent/fraction fields to an operand_class
package operand;

  typedef enum logic [2:0] {ZERO, SUBNORMAL, NORMAL, INF, QNAN, SNAN} operand_class;

  localparam int         BIAS     = 127;
  localparam logic [7:0] EXP_MAX  = 8'd255;
  localparam logic [9:0] ZERO_EXP = 10'h381;  // -127 in 10-bit two's complement
  localparam logic [9:0] INF_EXP  = 10'd128;

  function automatic operand_class classify(input logic [7:0] e, input logic [22:0] f);
    operand_class cls;
    if (e == 8'd0) begin
      cls = (f == 23'd0) ? ZERO : SUBNORMAL;
    end else if (e == EXP_MAX) begin
      if (f == 23'd0)  cls = INF;
      else if (f[22])  cls = QNAN;
      else             cls = SNAN;
    end else begin
      cls = NORMAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/operand_unpacker_if.sv
// rtl/operand_unpacker_if.sv - valid/ready bus between issue logic, unpacker and execute stages
// in_*  : operand pair + tag from the issue logic (in_ready flows back)
// out_* : unpacked sign/exponent/mantissa/class per operand + tag (out_ready flows back)
// master: issue/execute side; slave: the unpacker
interface operand_unpacker_if
  import operand::*;
#(
  parameter int TAG_WIDTH = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_operand_a;
  logic [31:0]          in_operand_b;
  logic [TAG_WIDTH-1:0] in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign_a;
  logic                 out_sign_b;
  logic [9:0]           out_exponent_a;
  logic [9:0]           out_exponent_b;
  logic [23:0]          out_mantissa_a;
  logic [23:0]          out_mantissa_b;
  operand_class         out_class_a;
  operand_class         out_class_b;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_operand_a, in_operand_b, in_tag, out_ready,
    input  in_ready, out_valid, out_sign_a, out_sign_b, out_exponent_a, out_exponent_b,
           out_mantissa_a, out_mantissa_b, out_class_a, out_class_b, out_tag
  );

  modport slave (
    input  in_valid, in_operand_a, in_operand_b, in_tag, out_ready,
    output in_ready, out_valid, out_sign_a, out_sign_b, out_exponent_a, out_exponent_b,
           out_mantissa_a, out_mantissa_b, out_class_a, out_class_b, out_tag
  );

endinterface

// File: rtl/operand_unpacker_lzc.sv
// rtl/operand_unpacker_lzc.sv - combinational leading-zero counter
// value : WIDTH-bit input
// count : number of zeros above the first set bit, WIDTH when value is all zero
module leading_zero_counter #(
  parameter int WIDTH = 23,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  logic found;

  always_comb begin
    count = CW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_unpacker.sv
// rtl/operand_unpacker.sv - two-stage IEEE-754 single operand unpack/classify/normalise pipeline
// clk     : rising-edge clock
// reset_n : asynchronous active-low reset
// flush   : synchronous kill of all in-flight entries
// bus     : operand_unpacker_if.slave (in_* operand pair in, out_* unpacked pair out)
module operand_unpacker
  import operand::*;
#(
  parameter int TAG_WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  operand_unpacker_if.slave bus
);

  logic                 s1_valid;
  logic                 s1_sign_a, s1_sign_b;
  logic [7:0]           s1_exp_a, s1_exp_b;
  logic [23:0]          s1_mant_a, s1_mant_b;
  logic [4:0]           s1_lzc_a, s1_lzc_b;
  operand_class         s1_class_a, s1_class_b;
  logic [TAG_WIDTH-1:0] s1_tag;

  logic       s2_open, s1_open, in_fire, s1_advance;
  logic [4:0] lzc_a, lzc_b;
  logic [9:0] norm_exp_a, norm_exp_b;
  logic [23:0] norm_mant_a, norm_mant_b;

  leading_zero_counter #(.WIDTH(23)) u_lzc_a (.value(bus.in_operand_a[22:0]), .count(lzc_a));
  leading_zero_counter #(.WIDTH(23)) u_lzc_b (.value(bus.in_operand_b[22:0]), .count(lzc_b));

  // A stage may load when empty or when its current entry moves on this cycle.
  assign s2_open      = !bus.out_valid || bus.out_ready;
  assign s1_open      = !s1_valid || s2_open;
  assign bus.in_ready = s1_open && !flush;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign s1_advance   = s1_valid && s2_open && !flush;

  // Returns {exponent, mantissa}. A subnormal is 0.f * 2^-126, so its first set
  // fraction bit lies lzc+1 places below the hidden bit: shift by lzc+1 and the
  // exponent becomes -127 - lzc.
  function automatic logic [33:0] normalise(input operand_class cls, input logic [7:0] e,
                                            input logic [23:0] m, input logic [4:0] lzc);
    logic [9:0]  ex;
    logic [23:0] mant;
    ex   = INF_EXP;
    mant = m;
    case (cls)
      NORMAL:    ex = {2'b00, e} - 10'(BIAS);
      SUBNORMAL: begin
        ex   = ZERO_EXP - {5'd0, lzc};
        mant = m << ({1'b0, lzc} + 6'd1);
      end
      ZERO: begin
        ex   = ZERO_EXP;
        mant = '0;
      end
      default: ;
    endcase
    return {ex, mant};
  endfunction

  always_comb begin
    {norm_exp_a, norm_mant_a} = normalise(s1_class_a, s1_exp_a, s1_mant_a, s1_lzc_a);
    {norm_exp_b, norm_mant_b} = normalise(s1_class_b, s1_exp_b, s1_mant_b, s1_lzc_b);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid           <= 1'b0;
      s1_sign_a          <= 1'b0;
      s1_sign_b          <= 1'b0;
      s1_exp_a           <= '0;
      s1_exp_b           <= '0;
      s1_mant_a          <= '0;
      s1_mant_b          <= '0;
      s1_lzc_a           <= '0;
      s1_lzc_b           <= '0;
      s1_class_a         <= ZERO;
      s1_class_b         <= ZERO;
      s1_tag             <= '0;
      bus.out_valid      <= 1'b0;
      bus.out_sign_a     <= 1'b0;
      bus.out_sign_b     <= 1'b0;
      bus.out_exponent_a <= '0;
      bus.out_exponent_b <= '0;
      bus.out_mantissa_a <= '0;
      bus.out_mantissa_b <= '0;
      bus.out_class_a    <= ZERO;
      bus.out_class_b    <= ZERO;
      bus.out_tag        <= '0;
    end else begin
      if (flush) begin
        s1_valid      <= 1'b0;
        bus.out_valid <= 1'b0;
      end else begin
        if (s1_open) s1_valid      <= bus.in_valid;
        if (s2_open) bus.out_valid <= s1_valid;
      end

      if (in_fire) begin
        s1_sign_a  <= bus.in_operand_a[31];
        s1_sign_b  <= bus.in_operand_b[31];
        s1_exp_a   <= bus.in_operand_a[30:23];
        s1_exp_b   <= bus.in_operand_b[30:23];
        s1_mant_a  <= {bus.in_operand_a[30:23] != 8'd0, bus.in_operand_a[22:0]};
        s1_mant_b  <= {bus.in_operand_b[30:23] != 8'd0, bus.in_operand_b[22:0]};
        s1_lzc_a   <= lzc_a;
        s1_lzc_b   <= lzc_b;
        s1_class_a <= classify(bus.in_operand_a[30:23], bus.in_operand_a[22:0]);
        s1_class_b <= classify(bus.in_operand_b[30:23], bus.in_operand_b[22:0]);
        s1_tag     <= bus.in_tag;
      end

      if (s1_advance) begin
        bus.out_sign_a     <= s1_sign_a;
        bus.out_sign_b     <= s1_sign_b;
        bus.out_exponent_a <= norm_exp_a;
        bus.out_exponent_b <= norm_exp_b;
        bus.out_mantissa_a <= norm_mant_a;
        bus.out_mantissa_b <= norm_mant_b;
        bus.out_class_a    <= s1_class_a;
        bus.out_class_b    <= s1_class_b;
        bus.out_tag        <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_operand_unpacker.sv
// tb/tb_operand_unpacker.sv - scoreboard bench for operand_unpacker
module tb_operand_unpacker;
  import operand::*;

  typedef struct packed {
    logic [3:0]  tag;
    logic        a_sign;
    logic [9:0]  a_exp;
    logic [23:0] a_mant;
    logic [2:0]  a_cls;
    logic        b_sign;
    logic [9:0]  b_exp;
    logic [23:0] b_mant;
    logic [2:0]  b_cls;
  } res_t;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  int   n_cmp = 0;
  int   n_fail = 0;
  res_t sb[$];

  operand_unpacker_if #(.TAG_WIDTH(4)) bus();

  operand_unpacker #(.TAG_WIDTH(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: value-based unpack, subnormal exponent from the position of f's MSB.
  function automatic logic [37:0] model_op(input logic [31:0] op);
    logic [7:0]  e;
    logic [22:0] f;
    logic [9:0]  ex;
    logic [23:0] m;
    logic [2:0]  c;
    int          p;
    e  = op[30:23];
    f  = op[22:0];
    m  = {1'b1, f};
    ex = 10'd128;
    c  = INF;
    if (e == 8'd0 && f == 23'd0) begin
      ex = 10'h381; m = 24'd0; c = ZERO;
    end else if (e == 8'd0) begin
      p = 0;
      for (int i = 0; i < 23; i++) if (f[i]) p = i;
      ex = 10'(p - 149);
      m  = 24'(f) << (23 - p);
      c  = SUBNORMAL;
    end else if (e == 8'hFF) begin
      c = (f == 23'd0) ? INF : (f[22] ? QNAN : SNAN);
    end else begin
      ex = 10'(int'(e) - 127);
      c  = NORMAL;
    end
    return {op[31], ex, m, c};
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    res_t r;
    r.tag = t;
    {r.a_sign, r.a_exp, r.a_mant, r.a_cls} = model_op(a);
    {r.b_sign, r.b_exp, r.b_mant, r.b_cls} = model_op(b);
    return r;
  endfunction

  // One cycle: drive at negedge, sample just after; push expected on input transfer.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t, input logic rdy, input logic fl,
                      output logic fi, output logic fo, output logic ov, output logic ir,
                      output res_t got);
    @(negedge clk);
    bus.in_valid = v; bus.in_operand_a = a; bus.in_operand_b = b; bus.in_tag = t;
    bus.out_ready = rdy; flush = fl;
    #1;
    ir = bus.in_ready;
    ov = bus.out_valid;
    fi = v && ir;
    fo = ov && rdy;
    got.tag = bus.out_tag;
    got.a_sign = bus.out_sign_a; got.a_exp = bus.out_exponent_a;
    got.a_mant = bus.out_mantissa_a; got.a_cls = bus.out_class_a;
    got.b_sign = bus.out_sign_b; got.b_exp = bus.out_exponent_b;
    got.b_mant = bus.out_mantissa_b; got.b_cls = bus.out_class_b;
    if (fi) sb.push_back(model(a, b, t));
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_operand_a = '0; bus.in_operand_b = '0; bus.in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
    n_cmp++; if (bus.out_class_a !== ZERO) begin n_fail++; $display("FAIL rst_class_a: got %0d, required ZERO", bus.out_class_a); end
    n_cmp++; if (bus.out_class_b !== ZERO) begin n_fail++; $display("FAIL rst_class_b: got %0d, required ZERO", bus.out_class_b); end
    n_cmp++; if (bus.out_mantissa_a !== 24'd0) begin n_fail++; $display("FAIL rst_mant_a: got %h, required 0", bus.out_mantissa_a); end
    n_cmp++; if (bus.out_exponent_b !== 10'd0) begin n_fail++; $display("FAIL rst_exp_b: got %h, required 0", bus.out_exponent_b); end
    n_cmp++; if (bus.out_tag !== 4'd0) begin n_fail++; $display("FAIL rst_tag: got %h, required 0", bus.out_tag); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 1", bus.in_ready); end
  endtask

  task automatic test_normal();
    res_t got, exp;
    logic fi, fo, ov, ir;
    int   lat = -1;
    step(1'b1, 32'h3F800000, 32'hC0200000, 4'h1, 1'b1, 1'b0, fi, fo, ov, ir, got);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b0, fi, fo, ov, ir, got);
      if (fo) begin
        if (lat < 0) lat = i;
        n_cmp++;
        if ({got.a_sign, got.a_exp, got.a_mant, got.a_cls} !== {1'b0, 10'd0, 24'h800000, 3'(NORMAL)}) begin
          n_fail++; $display("FAIL norm_a_fields: got %h, required 0_000_800000_NORMAL", {got.a_sign, got.a_exp, got.a_mant, got.a_cls});
        end
        n_cmp++;
        if ({got.b_sign, got.b_exp, got.b_mant} !== {1'b1, 10'd1, 24'hA00000}) begin
          n_fail++; $display("FAIL norm_b_fields: got %h, required 1_001_A00000", {got.b_sign, got.b_exp, got.b_mant});
        end
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL norm_unexpected: got %h, required no output", got); end
        else begin exp = sb.pop_front(); if (got !== exp) begin n_fail++; $display("FAIL norm_data: got %h, required %h", got, exp); end end
      end
    end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL norm_latency: got %0d, required 2", lat); end
    n_cmp++; if (sb.size() !== 0) begin n_fail++; $display("FAIL norm_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_subnormal();
    res_t got, exp;
    logic fi, fo, ov, ir;
    step(1'b1, 32'h00000001, 32'h00400000, 4'h2, 1'b1, 1'b0, fi, fo, ov, ir, got);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b0, fi, fo, ov, ir, got);
      if (fo) begin
        n_cmp++;
        if ({got.a_exp, got.a_mant, got.a_cls} !== {10'h36B, 24'h800000, 3'(SUBNORMAL)}) begin
          n_fail++; $display("FAIL subn_a_fields: got %h, required 36B_800000_SUBNORMAL", {got.a_exp, got.a_mant, got.a_cls});
        end
        n_cmp++;
        if ({got.b_exp, got.b_mant} !== {10'h381, 24'h800000}) begin
          n_fail++; $display("FAIL subn_b_fields: got %h, required 381_800000", {got.b_exp, got.b_mant});
        end
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL subn_unexpected: got %h, required no output", got); end
        else begin exp = sb.pop_front(); if (got !== exp) begin n_fail++; $display("FAIL subn_data: got %h, required %h", got, exp); end end
      end
    end
    n_cmp++; if (sb.size() !== 0) begin n_fail++; $display("FAIL subn_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_special();
    res_t got, exp;
    logic fi, fo, ov, ir;
    step(1'b1, 32'h7F800000, 32'h7FC00001, 4'h3, 1'b1, 1'b0, fi, fo, ov, ir, got);
    step(1'b1, 32'hFF800001, 32'h80000000, 4'h4, 1'b1, 1'b0, fi, fo, ov, ir, got);
    for (int i = 2; i < 10; i++) begin
      step(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b0, fi, fo, ov, ir, got);
      if (fo) begin
        if (got.tag == 4'h3) begin
          n_cmp++;
          if ({got.a_exp, got.a_cls} !== {10'd128, 3'(INF)}) begin
            n_fail++; $display("FAIL spec_inf: got %h, required 080_INF", {got.a_exp, got.a_cls});
          end
          n_cmp++;
          if ({got.b_mant, got.b_cls} !== {24'hC00001, 3'(QNAN)}) begin
            n_fail++; $display("FAIL spec_qnan: got %h, required C00001_QNAN", {got.b_mant, got.b_cls});
          end
        end else begin
          n_cmp++;
          if ({got.a_sign, got.a_cls} !== {1'b1, 3'(SNAN)}) begin
            n_fail++; $display("FAIL spec_snan: got %h, required 1_SNAN", {got.a_sign, got.a_cls});
          end
          n_cmp++;
          if ({got.b_sign, got.b_exp, got.b_mant, got.b_cls} !== {1'b1, 10'h381, 24'd0, 3'(ZERO)}) begin
            n_fail++; $display("FAIL spec_zero: got %h, required 1_381_000000_ZERO", {got.b_sign, got.b_exp, got.b_mant, got.b_cls});
          end
        end
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL spec_unexpected: got %h, required no output", got); end
        else begin exp = sb.pop_front(); if (got !== exp) begin n_fail++; $display("FAIL spec_data: got %h, required %h", got, exp); end end
      end
    end
    n_cmp++; if (sb.size() !== 0) begin n_fail++; $display("FAIL spec_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    res_t        got, exp, prev_got;
    logic        fi, fo, ov, ir, rdy, v;
    logic        prev_stall = 1'b0;
    logic        drop_seen = 1'b0;
    logic [31:0] va[8];
    logic [31:0] vb[8];
    int          idx = 0;
    int          delivered = 0;
    prev_got = '0;
    for (int i = 0; i < 8; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      if (i % 3 == 0) va[i] = va[i] & 32'h807FFFFF;
      if (i == 5) vb[i] = 32'h7F800000 | (vb[i] & 32'h803FFFFF);
    end
    for (int c = 0; c < 40 && delivered < 8; c++) begin
      rdy = !(c >= 2 && c <= 4);
      v = (idx < 8);
      step(v, v ? va[idx] : 32'd0, v ? vb[idx] : 32'd0, 4'(idx), rdy, 1'b0, fi, fo, ov, ir, got);
      if (fi) idx++;
      if (v && !ir && !drop_seen) begin
        drop_seen = 1'b1;
        n_cmp++; if (sb.size() !== 2) begin n_fail++; $display("FAIL b2b_fill: got %0d accepted, required 2", sb.size()); end
      end
      if (prev_stall) begin
        n_cmp++;
        if (!ov || got !== prev_got) begin n_fail++; $display("FAIL b2b_stable: got %b/%h, required 1/%h", ov, got, prev_got); end
      end
      prev_stall = ov && !rdy;
      prev_got = got;
      if (fo) begin
        delivered++;
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_unexpected: got %h, required no output", got); end
        else begin exp = sb.pop_front(); if (got !== exp) begin n_fail++; $display("FAIL b2b_data: got %h, required %h", got, exp); end end
      end
    end
    n_cmp++; if (!drop_seen) begin n_fail++; $display("FAIL b2b_backpressure: got no in_ready drop, required one"); end
    n_cmp++; if (delivered !== 8 || idx !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d in/%0d out, required 8/8", idx, delivered); end
  endtask

  task automatic test_flush();
    res_t got, exp;
    logic fi, fo, ov, ir;
    logic leaked = 1'b0;
    step(1'b1, 32'h3F800000, 32'h3F800000, 4'h6, 1'b0, 1'b0, fi, fo, ov, ir, got);
    step(1'b1, 32'h40000000, 32'h40000000, 4'h7, 1'b0, 1'b0, fi, fo, ov, ir, got);
    step(1'b1, 32'h40400000, 32'h40400000, 4'h8, 1'b0, 1'b1, fi, fo, ov, ir, got);
    n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL flush_full: got out_valid %b, required 1", ov); end
    n_cmp++; if (ir !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b, required 0", ir); end
    sb.delete();
    step(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b0, fi, fo, ov, ir, got);
    n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b, required 0", ov); end
    n_cmp++; if (ir !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b, required 1", ir); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b0, fi, fo, ov, ir, got);
      if (ov) leaked = 1'b1;
    end
    n_cmp++; if (leaked) begin n_fail++; $display("FAIL flush_leak: got flushed entry on out_*, required none"); end
    step(1'b1, 32'hBF000000, 32'h00000010, 4'hC, 1'b1, 1'b0, fi, fo, ov, ir, got);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b0, fi, fo, ov, ir, got);
      if (fo) begin
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL flush_unexpected: got %h, required no output", got); end
        else begin exp = sb.pop_front(); if (got !== exp) begin n_fail++; $display("FAIL flush_data: got %h, required %h", got, exp); end end
      end
    end
    n_cmp++; if (sb.size() !== 0) begin n_fail++; $display("FAIL flush_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    res_t got, exp;
    logic fi, fo, ov, ir;
    int   lat = -1;
    step(1'b1, 32'h3F800000, 32'h40000000, 4'h9, 1'b1, 1'b0, fi, fo, ov, ir, got);
    step(1'b1, 32'h40400000, 32'h40800000, 4'hA, 1'b1, 1'b0, fi, fo, ov, ir, got);
    step(1'b1, 32'h40A00000, 32'h40C00000, 4'hB, 1'b1, 1'b0, fi, fo, ov, ir, got);
    n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b, required 1", ov); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b, required 0", bus.out_valid); end
    n_cmp++; if (bus.out_tag !== 4'd0) begin n_fail++; $display("FAIL rmid_out_tag: got %h, required 0", bus.out_tag); end
    sb.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    step(1'b1, 32'h40490FDB, 32'h00000003, 4'h5, 1'b1, 1'b0, fi, fo, ov, ir, got);
    n_cmp++; if (fi !== 1'b1) begin n_fail++; $display("FAIL rmid_accept: got %b, required 1", fi); end
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b0, fi, fo, ov, ir, got);
      if (fo) begin
        if (lat < 0) lat = i;
        n_cmp++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rmid_unexpected: got %h, required no output", got); end
        else begin exp = sb.pop_front(); if (got !== exp) begin n_fail++; $display("FAIL rmid_data: got %h, required %h", got, exp); end end
      end
    end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL rmid_latency: got %0d, required 2", lat); end
    n_cmp++; if (sb.size() !== 0) begin n_fail++; $display("FAIL rmid_drain: got %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_subnormal();
    test_special();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
